// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the line_window_buffer / Convolutor pair.
//   DEF_DATA_W : default pixel width in bits
//   K          : window edge length (3x3 window)
//   win_idx    : flat element index of window element (r,c); r=0 is the
//                oldest row, c=0 the leftmost column. Element (r,c) sits at
//                bits [win_idx(r,c)*DATA_W +: DATA_W] of a packed window.
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned K          = 3;

    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
        return r * K + c;
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// ---------------------------------------------------------------------------
// line_buffer_ram
// Storage for the two previous image rows, one word per column. Each word
// packs {lb1, lb0}: lb1 is the row two above the current one, lb0 the row
// directly above. Asynchronous read, synchronous write, single shared
// address. Contents are not reset.
// Ports:
//   i_clk   : write clock, rising edge
//   i_we    : write enable
//   i_addr  : column address (read and write)
//   i_wdata : word written at i_addr
//   o_rdata : word currently stored at i_addr
// ---------------------------------------------------------------------------
module line_buffer_ram #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/line_window_buffer.sv
// ---------------------------------------------------------------------------
// line_window_buffer
// Turns a raster-order pixel stream into 3x3 windows for the Convolutor.
// Only full windows (col>=2, row>=2) are emitted, through a single output
// register with valid/ready handshake and no bubble.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   in_pix     : input pixel
//   in_valid   : in_pix is valid
//   in_ready   : pixel accepted this cycle when in_valid is also high
//   win        : 3x3 window, element (r,c) at [win_idx(r,c)*DATA_W +: DATA_W]
//   win_valid  : win holds an unconsumed window
//   win_ready  : consumer takes win this cycle
//   win_last   : last window of the frame (qualified by win_valid)
//   in_sof     : start of frame, only with LINE_WINDOW_SOF_EN defined
// Build option:
//   LINE_WINDOW_SOF_EN : adds in_sof; an accepted pixel with in_sof=1 is
//                        taken as row 0, col 0.
// ---------------------------------------------------------------------------
module line_window_buffer
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     in_pix,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [K*K*DATA_W-1:0] win,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic                  win_last
`ifdef LINE_WINDOW_SOF_EN
    ,
    input  logic                  in_sof
`endif
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [CW-1:0]         w_col;
    logic [RW-1:0]         w_row;
    logic                  w_acc;
    logic                  w_sof;
    logic                  w_emit;
    logic                  w_col_end;
    logic                  w_row_end;
    logic [2*DATA_W-1:0]   w_rdata;
    logic [DATA_W-1:0]     w_lb0;
    logic [DATA_W-1:0]     w_lb1;
    // r_c1/r_c2 hold the two most recent columns (older/newer), rows 0..2
    logic [DATA_W-1:0]     r_c1   [K];
    logic [DATA_W-1:0]     r_c2   [K];
    logic [DATA_W-1:0]     w_cnew [K];
    logic [K*K*DATA_W-1:0] w_win_next;
    logic [K*K*DATA_W-1:0] r_win;
    logic                  r_win_valid;
    logic                  r_win_last;

    assign in_ready  = !r_win_valid || win_ready;
    assign w_acc     = in_valid && in_ready;

`ifdef LINE_WINDOW_SOF_EN
    assign w_sof     = in_sof;
`else
    assign w_sof     = 1'b0;
`endif

    // Position of the pixel being presented; SOF overrides the counters.
    assign w_col     = w_sof ? '0 : r_col;
    assign w_row     = w_sof ? '0 : r_row;
    assign w_col_end = (w_col == COL_LAST);
    assign w_row_end = (w_row == ROW_LAST);
    assign w_emit    = w_acc && (w_col >= CW'(2)) && (w_row >= RW'(2));

    line_buffer_ram #(
        .DEPTH (IMG_W),
        .WIDTH (2*DATA_W),
        .AW    (CW)
    ) u_lb (
        .i_clk   (clk),
        .i_we    (w_acc),
        .i_addr  (w_col),
        .i_wdata ({w_lb0, in_pix}),
        .o_rdata (w_rdata)
    );

    assign {w_lb1, w_lb0} = w_rdata;

    always_comb begin
        w_cnew[0] = w_lb1;
        w_cnew[1] = w_lb0;
        w_cnew[2] = in_pix;
    end

    // Window as it looks after shifting in the presented column.
    always_comb begin
        w_win_next = '0;
        for (int unsigned r = 0; r < K; r++) begin
            w_win_next[win_idx(r, 0)*DATA_W +: DATA_W] = r_c1[r];
            w_win_next[win_idx(r, 1)*DATA_W +: DATA_W] = r_c2[r];
            w_win_next[win_idx(r, 2)*DATA_W +: DATA_W] = w_cnew[r];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : w_row + RW'(1);
            end else begin
                r_col <= w_col + CW'(1);
                r_row <= w_row;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < K; r++) begin
                r_c1[r] <= '0;
                r_c2[r] <= '0;
            end
        end else if (w_acc) begin
            for (int unsigned r = 0; r < K; r++) begin
                r_c1[r] <= r_c2[r];
                r_c2[r] <= w_cnew[r];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win       <= '0;
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
        end else if (w_emit) begin
            r_win       <= w_win_next;
            r_win_valid <= 1'b1;
            r_win_last  <= w_col_end && w_row_end;
        end else if (win_ready) begin
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
        end
    end

    assign win       = r_win;
    assign win_valid = r_win_valid;
    assign win_last  = r_win_last;

endmodule
